// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per clock: shift-add for MULT/MULTU and restoring
// division for DIV/DIVU. Operands are reduced to magnitudes on entry, and
// the signs are reapplied in a single FIX cycle before HI/LO are written.
//
// Handshake: start is sampled only while busy=0. An accepted start launches
// an op, and done pulses for exactly one cycle when HI/LO hold the result.
// The done cycle is already idle, so a start in that cycle is accepted.
// MTHI/MTLO writes take effect only in an idle cycle with no start.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  // acc holds {upper, lower}: product halves for MUL, {remainder, quotient} for DIV
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // multiplicand for MUL, divisor for DIV (magnitude)
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh, diff;
  logic               no_borrow;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Next-state, datapath step and result sign fix-up
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dbz_pend_d = dbz_pend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;

    // op[0] selects the signed variants; magnitudes are taken only for those
    a_neg = op[0] & a[WIDTH-1];
    b_neg = op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;

    // Shift-add: add the multiplicand into the upper half when the multiplier LSB is set
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: the remainder never reaches the divisor, so W+1 bits hold the shifted value
    rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff      = rem_sh - {1'b0, opnd_q};
    no_borrow = ~diff[WIDTH];
    div_next  = {(no_borrow ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], no_borrow};

    // With a zero divisor the remainder path ends as |a|, so the remainder sign fix restores a
    prod_fix = neg_lo_q ? -acc_q : acc_q;
    quo_fix  = dbz_pend_q ? '1 : (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CALC;
          count_d    = '0;
          is_div_d   = op[1];
          neg_lo_d   = a_neg ^ b_neg;
          neg_hi_d   = a_neg;
          dbz_pend_d = op[1] & (b == '0);
          opnd_d     = op[1] ? b_mag : a_mag;
          acc_d      = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_CALC: begin
        acc_d   = is_div_q ? div_next : mul_next;
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        dbz_d   = dbz_pend_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset aborts any op in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dbz_pend_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      dbz_pend_q <= dbz_pend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (WIDTH=32): constant vector table,
// handshake/reset sequences and randomized ops against an arithmetic model.
module tb_mdu_iter;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          hi_we = 1'b0;
  logic          lo_we = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  int total = 0;
  int bad = 0;

  // Expected {div_by_zero, hi, lo} per launched op
  logic [2*W:0] exp_q[$];
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } vec_t;

  vec_t vecs[13];

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics from plain integer arithmetic
  function automatic logic [2*W:0] model(input logic [1:0] mop, input logic [W-1:0] ma,
                                         input logic [W-1:0] mb);
    logic [63:0] p;
    longint sp;
    int sa, sb, q, r;
    sa = $signed(ma);
    sb = $signed(mb);
    case (mop)
      2'd0: begin
        p = {32'h0, ma} * {32'h0, mb};
        return {1'b0, p};
      end
      2'd1: begin
        sp = longint'(sa) * longint'(sb);
        return {1'b0, 64'(sp)};
      end
      2'd2: begin
        if (mb == 0) return {1'b1, ma, 32'hFFFF_FFFF};
        return {1'b0, ma % mb, ma / mb};
      end
      default: begin
        if (mb == 0) return {1'b1, ma, 32'hFFFF_FFFF};
        if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, 32'(r), 32'(q)};
      end
    endcase
  endfunction

  // Drive a start for one clock edge (caller is away from the edge)
  task automatic launch(input logic [1:0] lop, input logic [W-1:0] la, input logic [W-1:0] lb);
    op = lop;
    a = la;
    b = lb;
    start = 1'b1;
    exp_q.push_back(model(lop, la, lb));
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  // Wait for done, checking hold/latency; optionally inject start+MTLO at a given cycle
  task automatic wait_done(input int inject_at);
    int n;
    bit got;
    logic [2*W:0] e;
    n = 0;
    got = 0;
    while (!got && n < LAT + 20) begin
      if (inject_at != 0 && n == inject_at) begin
        start = 1'b1;
        op = 2'd2;
        a = $urandom;
        b = $urandom;
        lo_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      lo_we = 1'b0;
      if (done) got = 1;
      else if (n == 2 || n == W / 2 || n == W) begin
        check("hold_hi", 64'(hi), 64'(cur_hi));
        check("hold_lo", 64'(lo), 64'(cur_lo));
        check("busy_calc", 64'(busy), 64'd1);
      end
    end
    if (!got) begin
      check("done_timeout", 64'd0, 64'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      check("latency", 64'(n), 64'(LAT));
      check("busy_at_done", 64'(busy), 64'd0);
      e = exp_q.pop_front();
      check("model_hi", 64'(hi), 64'(e[63:32]));
      check("model_lo", 64'(lo), 64'(e[31:0]));
      check("model_dbz", 64'(div_by_zero), 64'(e[64]));
      cur_hi = e[63:32];
      cur_lo = e[31:0];
    end
  endtask

  initial begin
    bit seen_done;
    logic [1:0] rop;
    logic [W-1:0] ra, rb;

    vecs[0]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{2'd1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2]  = '{2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{2'd2, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vecs[4]  = '{2'd0, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A, 1'b0};
    vecs[5]  = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6]  = '{2'd2, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[7]  = '{2'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[9]  = '{2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[10] = '{2'd3, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[11] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[12] = '{2'd3, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000, 1'b0};

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);

    // MTHI + MTLO together, then MTHI alone
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_both_hi", 64'(hi), 64'h1234_5678);
    check("mt_both_lo", 64'(lo), 64'h1234_5678);
    hi_we = 1'b1; wdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    hi_we = 1'b0;
    check("mthi_hi", 64'(hi), 64'h0BAD_F00D);
    check("mthi_lo_held", 64'(lo), 64'h1234_5678);
    cur_hi = 32'h0BAD_F00D;
    cur_lo = 32'h1234_5678;

    // Vector table
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(0);
      check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
      check($sformatf("vec%0d_dbz", i), 64'(div_by_zero), 64'(vecs[i].dbz));
      @(posedge clk); #1;
      check("done_pulse", 64'(done), 64'd0);
      check("dbz_held", 64'(div_by_zero), 64'(vecs[i].dbz));
    end

    // Start + MTLO while busy at cycle 5 are ignored
    @(negedge clk);
    launch(2'd0, 32'd7, 32'd6);
    wait_done(4);
    check("hs_hi", 64'(hi), 64'h0);
    check("hs_lo", 64'(lo), 64'h2A);
    // Start in the done cycle is accepted: DIVU by zero, then MULTU back to back
    launch(2'd2, 32'h64, 32'h0);
    wait_done(0);
    check("b2b_dbz_set", 64'(div_by_zero), 64'd1);
    launch(2'd0, 32'd3, 32'd5);
    check("dbz_held_busy", 64'(div_by_zero), 64'd1);
    wait_done(0);
    check("b2b_dbz_clr", 64'(div_by_zero), 64'd0);

    // Start and MTLO in the same idle cycle: start wins
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    launch(2'd1, 32'hFFFF_FFFE, 32'd9);
    lo_we = 1'b0;
    check("start_wins_lo", 64'(lo), 64'(cur_lo));
    wait_done(0);

    // Mid-op reset: leave a div-by-zero result in place, then abort a MULT
    @(negedge clk);
    launch(2'd3, 32'hFFFF_FFF9, 32'h0);
    wait_done(0);
    @(negedge clk);
    launch(2'd1, 32'hFFFF_FFFB, 32'd9);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    check("mid_rst_dbz", 64'(div_by_zero), 64'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    cur_hi = '0;
    cur_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    repeat (LAT + 6) begin
      @(posedge clk); #1;
      if (done) seen_done = 1;
    end
    check("no_done_after_rst", 64'(seen_done), 64'd0);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      @(negedge clk);
      launch(rop, ra, rb);
      wait_done(0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
